// File: rtl/puf_vote_pkg.sv
// Shared types and defaults for the PUF majority voter.
package puf_vote_pkg;
  localparam int unsigned RESP_W            = 16;
  localparam int unsigned DEF_NUM_EVAL      = 5;
  localparam int unsigned DEF_LOW_CYCLES    = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FIRE,
    ST_SAMPLE,
    ST_DONE
  } vote_state_t;
endpackage

// File: rtl/vote_counter.sv
// Per-bit vote accumulator; the threshold outputs include the sample being added this cycle.
module vote_counter #(
  parameter int unsigned NUM_EVAL = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample,
  input  logic resp_bit,
  output logic majority,
  output logic unstable
);
  localparam int unsigned CW = $clog2(NUM_EVAL + 1);
  localparam logic [CW-1:0] HALF = CW'(NUM_EVAL / 2);
  localparam logic [CW-1:0] FULL = CW'(NUM_EVAL);

  logic [CW-1:0] count;
  logic [CW-1:0] sum;

  always_comb begin
    sum      = count + CW'(sample & resp_bit);
    majority = (sum > HALF);
    unstable = (sum != '0) && (sum != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (sample) count <= sum;
  end
endmodule

// File: rtl/puf_majority_voter.sv
// Repeats PUF evaluations per challenge and reports a per-bit majority vote plus an instability mask.
module puf_majority_voter
  import puf_vote_pkg::*;
#(
  parameter int unsigned NUM_EVAL      = DEF_NUM_EVAL,
  parameter int unsigned LOW_CYCLES    = DEF_LOW_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              puf_trigger,
  input  logic [RESP_W-1:0] puf_response,
  output logic [RESP_W-1:0] response_out,
  output logic [RESP_W-1:0] unstable_mask,
  output logic              valid,
  output logic              busy
);
  localparam int unsigned EW = $clog2(NUM_EVAL + 1);
  localparam logic [EW-1:0] EVAL_LAST   = EW'(NUM_EVAL - 1);
  localparam logic [15:0]   LOW_LAST    = 16'(LOW_CYCLES - 1);
  localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  vote_state_t       state;
  logic [15:0]       timer;
  logic [EW-1:0]     eval_cnt;
  logic [RESP_W-1:0] majority;
  logic [RESP_W-1:0] unstable;
  logic              clear;
  logic              sample;

  always_comb begin
    clear  = (state == ST_IDLE) && start;
    sample = (state == ST_SAMPLE);
  end

  for (genvar i = 0; i < RESP_W; i++) begin : g_bit
    vote_counter #(.NUM_EVAL(NUM_EVAL)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .sample   (sample),
      .resp_bit (puf_response[i]),
      .majority (majority[i]),
      .unstable (unstable[i])
    );
  end

  // Outputs are loaded on the final SAMPLE edge from the counters' look-ahead sums,
  // so they are already valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      timer         <= '0;
      eval_cnt      <= '0;
      puf_trigger   <= 1'b0;
      valid         <= 1'b0;
      busy          <= 1'b0;
      response_out  <= '0;
      unstable_mask <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state       <= ST_ARM;
          timer       <= '0;
          eval_cnt    <= '0;
          busy        <= 1'b1;
          puf_trigger <= 1'b0;
        end
        ST_ARM: if (timer == LOW_LAST) begin
          state       <= ST_FIRE;
          timer       <= '0;
          puf_trigger <= 1'b1;
        end else begin
          timer <= timer + 16'd1;
        end
        ST_FIRE: if (timer == SETTLE_LAST) begin
          state <= ST_SAMPLE;
          timer <= '0;
        end else begin
          timer <= timer + 16'd1;
        end
        ST_SAMPLE: begin
          eval_cnt    <= eval_cnt + EW'(1);
          puf_trigger <= 1'b0;
          if (eval_cnt == EVAL_LAST) begin
            state         <= ST_DONE;
            valid         <= 1'b1;
            response_out  <= majority;
            unstable_mask <= unstable;
          end else begin
            state <= ST_ARM;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          puf_trigger <= 1'b0;
        end
      endcase
    end
  end
endmodule
